// File: rtl/cpu_bus_bridge_pkg.sv
// Shared CPU definitions: the read/write select and the bridge FSM state encodings.
package cpu_bus_bridge_pkg;

  typedef enum logic {
    CPU_RD = 1'b0,
    CPU_WR = 1'b1
  } cpu_rdwr_e;

  localparam int CPU_STATE_MSB = 1;

  typedef enum logic [CPU_STATE_MSB:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_ACK = 2'b01,
    ST_RESP     = 2'b10
  } bus_state_e;

endpackage

// File: rtl/cpu_bus_timeout.sv
// WAIT_ACK watchdog for cpu_bus_bridge; exists only when CPU_BUS_TIMEOUT_EN is defined.
`ifdef CPU_BUS_TIMEOUT_EN
module cpu_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  // Counts WAIT_ACK cycles; it sits at zero outside WAIT_ACK, so every access starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_run) begin
      r_count <= '0;
    end else if (!o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = i_run && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/cpu_bus_bridge.sv
// Stalls the CPU while a single memory access runs through IDLE -> WAIT_ACK -> RESP.
// Optional CPU_BUS_TIMEOUT_EN aborts a WAIT_ACK that never sees mem_ack.
module cpu_bus_bridge
  import cpu_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_rdwr,
  input  cpu_rdwr_e             cpu_which_rdwr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_enable,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_err
);

  bus_state_e            r_state;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_cpu_data_in;
  logic                  r_bus_err;
  logic                  w_timeout;

`ifdef CPU_BUS_TIMEOUT_EN
  cpu_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst),
    .i_run    (r_state == ST_WAIT_ACK),
    .o_expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: state is updated with <= only, so every branch sees the pre-edge values of r_*.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_cpu_data_in <= '0;
      r_bus_err     <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req_rdwr) begin
            r_mem_addr  <= cpu_addr;
            r_mem_wdata <= cpu_data_out;
            r_mem_we    <= (cpu_which_rdwr == CPU_WR);
            r_mem_req   <= 1'b1;
            r_state     <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // A real acknowledge wins over a timeout landing in the same cycle.
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) r_cpu_data_in <= mem_rdata;
            r_state   <= ST_RESP;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) r_cpu_data_in <= '1;
            r_bus_err <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Gated by rst so the CPU stays stalled for the whole reset, not just the registered part.
  assign cpu_enable  = rst && (((r_state == ST_IDLE) && !cpu_req_rdwr) || (r_state == ST_RESP));
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign cpu_data_in = r_cpu_data_in;
  assign bus_err     = r_bus_err;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Scoreboard bench for cpu_bus_bridge: drivers push expected RESP results, a monitor pops them.
module tb_cpu_bus_bridge;
  import cpu_bus_bridge_pkg::*;

  logic        clk;
  logic        rst;
  logic        cpu_req_rdwr;
  cpu_rdwr_e   cpu_which_rdwr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in;
  logic        cpu_enable;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  model_rd;
  int          n_total;
  int          n_bad;
  bit          pending;

  cpu_bus_bridge #(
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_rdwr  (cpu_req_rdwr),
    .cpu_which_rdwr(cpu_which_rdwr),
    .cpu_addr      (cpu_addr),
    .cpu_data_out  (cpu_data_out),
    .cpu_data_in   (cpu_data_in),
    .cpu_enable    (cpu_enable),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .bus_err       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: a RESP is the first enabled cycle after mem_req was seen high.
  initial begin
    pending = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        pending = 1'b0;
      end else if (mem_req) begin
        pending = 1'b1;
      end else if (pending && cpu_enable) begin
        pending = 1'b0;
        if (sb_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_data", {24'd0, cpu_data_in}, {24'd0, e.data});
          check("resp_err", {31'd0, bus_err}, {31'd0, e.err});
        end
      end
    end
  end

  // Called at an IDLE negedge; returns at the following IDLE negedge.
  task automatic access(input cpu_rdwr_e rw, input logic [15:0] addr, input logic [7:0] wd,
                        input logic [7:0] rd, input int delay, input bit keep);
    exp_t e;
    cpu_req_rdwr   = 1'b1;
    cpu_which_rdwr = rw;
    cpu_addr       = addr;
    cpu_data_out   = wd;
    if (rw == CPU_RD) model_rd = rd;
    e.data = model_rd;
    e.err  = 1'b0;
    sb_q.push_back(e);
    #1;
    check("idle_enable", {31'd0, cpu_enable}, 32'd0);
    check("idle_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    if (!keep) cpu_req_rdwr = 1'b0;
    cpu_addr     = ~addr;
    cpu_data_out = ~wd;
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = ~rd;
      end
      #1;
      check("wait_req", {31'd0, mem_req}, 32'd1);
      check("wait_enable", {31'd0, cpu_enable}, 32'd0);
      check("wait_addr", {16'd0, mem_addr}, {16'd0, addr});
      check("wait_we", {31'd0, mem_we}, {31'd0, rw == CPU_WR});
      if (rw == CPU_WR) check("wait_wdata", {24'd0, mem_wdata}, {24'd0, wd});
      @(negedge clk);
      mem_ack = 1'b0;
    end
    #1;
    check("resp_enable", {31'd0, cpu_enable}, 32'd1);
    check("resp_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    n_total        = 0;
    n_bad          = 0;
    model_rd       = 8'h00;
    rst            = 1'b0;
    cpu_req_rdwr   = 1'b1;
    cpu_which_rdwr = CPU_WR;
    cpu_addr       = 16'hFFFF;
    cpu_data_out   = 8'hFF;
    mem_rdata      = 8'h00;
    mem_ack        = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_enable", {31'd0, cpu_enable}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_rdata", {24'd0, cpu_data_in}, 32'd0);
    check("rst_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    rst          = 1'b1;
    cpu_req_rdwr = 1'b0;
    @(negedge clk);

    access(CPU_RD, 16'h2329, 8'h00, 8'hA5, 0, 1'b0);
    access(CPU_WR, 16'h9001, 8'h5A, 8'hEE, 4, 1'b0);

    // Stray acknowledge while idle must not disturb anything.
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray_ack_data", {24'd0, cpu_data_in}, 32'h0000_00A5);
    check("stray_ack_req", {31'd0, mem_req}, 32'd0);
    check("stray_ack_enable", {31'd0, cpu_enable}, 32'd1);
    @(negedge clk);

    access(CPU_RD, 16'h1234, 8'h00, 8'h11, 0, 1'b1);
    access(CPU_RD, 16'h1235, 8'h00, 8'h22, 2, 1'b0);

    for (int k = 0; k < 6; k++) begin
      cpu_rdwr_e rw;
      rw = ($urandom_range(0, 1) == 1) ? CPU_WR : CPU_RD;
      access(rw, 16'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 5)), 1'b0);
    end

`ifdef CPU_BUS_TIMEOUT_EN
    begin
      exp_t e;
      cpu_req_rdwr   = 1'b1;
      cpu_which_rdwr = CPU_RD;
      cpu_addr       = 16'h4000;
      model_rd       = 8'hFF;
      e.data = 8'hFF;
      e.err  = 1'b1;
      sb_q.push_back(e);
      @(negedge clk);
      cpu_req_rdwr = 1'b0;
      for (int i = 0; i < 15; i++) begin
        #1;
        check("to_wait_req", {31'd0, mem_req}, 32'd1);
        check("to_wait_err", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
      end
      #1;
      check("to_resp_enable", {31'd0, cpu_enable}, 32'd1);
      check("to_resp_err", {31'd0, bus_err}, 32'd1);
      @(negedge clk);
      #1;
      check("to_err_pulse", {31'd0, bus_err}, 32'd0);
      @(negedge clk);
    end
`else
    access(CPU_RD, 16'h4000, 8'h00, 8'h3C, 30, 1'b0);
`endif

    // Reset in the middle of WAIT_ACK, followed by acknowledges that must be ignored.
    cpu_req_rdwr   = 1'b1;
    cpu_which_rdwr = CPU_RD;
    cpu_addr       = 16'h0BAD;
    @(negedge clk);
    cpu_req_rdwr = 1'b0;
    @(negedge clk);
    #1;
    check("mid_req_before", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_req_dropped", {31'd0, mem_req}, 32'd0);
    check("mid_enable", {31'd0, cpu_enable}, 32'd0);
    check("mid_rdata", {24'd0, cpu_data_in}, 32'd0);
    model_rd = 8'h00;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 8'hC3;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("late_ack_req", {31'd0, mem_req}, 32'd0);
      check("late_ack_rdata", {24'd0, cpu_data_in}, 32'd0);
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
